sramlike_mem_slave: RTL and testbench

//  Responder end of the team's SRAM-like bus (req/wr/size/addr/wdata -> addr_ok/data_ok/rdata).

---
 rtl/sramlike_mem_slave.sv | 149 ++++++++++++++
 tb/tb_sramlike_mem_slave.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_mem_slave.sv
// Responder for the SRAM-like bus: word-organised memory with fixed access latency and byte-lane write masks.
// Optional backpressure model enabled by defining SRAMLIKE_RAND_STALL_EN (LFSR-gated addr_ok).
module sramlike_mem_slave #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          LATENCY    = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    w_accept;
  logic                    w_stall_ok;
  logic                    w_done_nxt;

  logic                    r_wr;
  logic [1:0]              r_size;
  logic [ADDR_WIDTH+1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic                    r_data_ok;
  logic [31:0]             r_rdata;

  logic                    w_wr_nxt;
  logic [ADDR_WIDTH+1:0]   w_addr_nxt;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [ADDR_WIDTH-1:0]   w_idx_nxt;
  logic [3:0]              w_mask;
  logic [31:0]             w_mask_bits;
  logic [31:0]             w_merged;

  logic [31:0]             r_mem [2**ADDR_WIDTH];

`ifdef SRAMLIKE_RAND_STALL_EN
  logic [15:0] r_lfsr;
  logic        w_fb;
  logic        w_unused_addr;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign w_stall_ok    = r_lfsr[0];
  assign w_unused_addr = &{1'b0, addr[31:ADDR_WIDTH+2]};
`else
  logic w_unused_addr;

  assign w_stall_ok    = 1'b1;
  assign w_unused_addr = &{1'b0, addr[31:ADDR_WIDTH+2], LFSR_SEED};
`endif

  assign w_accept = req & (r_state == S_IDLE) & w_stall_ok;
  assign addr_ok  = w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LP_CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // data_ok is registered and covers the final WAIT cycle (cnt == 0); RESP is the turnaround cycle
  // that gives the LATENCY + 2 request spacing. The write commits on the edge ending data_ok.
  assign w_done_nxt = (w_state_nxt == S_WAIT) && (w_cnt_nxt == 4'd0);

  assign w_wr_nxt   = w_accept ? wr : r_wr;
  assign w_addr_nxt = w_accept ? addr[ADDR_WIDTH+1:0] : r_addr;
  assign w_idx_nxt  = w_addr_nxt[ADDR_WIDTH+1:2];
  assign w_idx      = r_addr[ADDR_WIDTH+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data_ok <= w_done_nxt;
      if (w_accept) begin
        r_wr    <= wr;
        r_size  <= size;
        r_addr  <= addr[ADDR_WIDTH+1:0];
        r_wdata <= wdata;
      end
      if (w_done_nxt && !w_wr_nxt) r_rdata <= r_mem[w_idx_nxt];
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   w_mask = 4'b0001 << r_addr[1:0];
      2'b01:   w_mask = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    w_mask_bits = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_mask_bits[8*k +: 8] = {8{w_mask[k]}};
    end
    w_merged = (r_mem[w_idx] & ~w_mask_bits) | (r_wdata & w_mask_bits);
  end

  always_ff @(posedge clk) begin
    if (!rst && r_data_ok && r_wr) r_mem[w_idx] <= w_merged;
  end

  assign data_ok = r_data_ok;
  assign rdata   = r_rdata;

endmodule

// File: tb/tb_sramlike_mem_slave.sv
// Directed bench for sramlike_mem_slave: LATENCY=3 instance for the main table and corner cases,
// LATENCY=1 instance for the short-latency build.
module tb_sramlike_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req, wr, sel;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic        req0, req1;
  logic [31:0] rdata0, rdata1;
  logic        aok0, aok1, dok0, dok1;
  logic        aok, dok;
  logic [31:0] rd;

  always #5 clk = ~clk;

  assign req0 = req & ~sel;
  assign req1 = req & sel;
  assign aok  = sel ? aok1 : aok0;
  assign dok  = sel ? dok1 : dok0;
  assign rd   = sel ? rdata1 : rdata0;

  sramlike_mem_slave #(.ADDR_WIDTH(12), .LATENCY(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .req(req0), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .addr_ok(aok0), .data_ok(dok0)
  );

  sramlike_mem_slave #(.ADDR_WIDTH(12), .LATENCY(1), .LFSR_SEED(16'hACE1)) dut_l1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .addr_ok(aok1), .data_ok(dok1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_rd [2];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic txn(input logic s, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                     input string nm);
    int lat;
    bit acc, got;
    int exp_lat;
    exp_lat = s ? 1 : 3;
    @(posedge clk); #1;
    sel = s; req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = aok;
    end
    check({nm, " accept"}, 32'(acc), 32'd1);
    if (!acc) begin
      req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req = 1'b0; wr = ~w; size = ~sz; addr = ~a; wdata = ~d;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = dok;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (w) begin
      check({nm, " rdata held"}, rd, last_rd[s]);
    end else begin
      check({nm, " rdata"}, rd, e);
      last_rd[s] = e;
    end
    @(negedge clk);
    check({nm, " single pulse"}, 32'(dok), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_cyc [$];
    int nd, overlap;
    bit acc;

    vecs[0]  = '{1'b1, 2'b10, 32'h100,  32'h11223344, 32'h0,        "wr word 100"};
    vecs[1]  = '{1'b0, 2'b10, 32'h100,  32'h0,        32'h11223344, "rd word 100"};
    vecs[2]  = '{1'b1, 2'b00, 32'h103,  32'hAB000000, 32'h0,        "wr byte 103"};
    vecs[3]  = '{1'b0, 2'b10, 32'h100,  32'h0,        32'hAB223344, "rd after byte"};
    vecs[4]  = '{1'b1, 2'b01, 32'h100,  32'h0000BEEF, 32'h0,        "wr half 100"};
    vecs[5]  = '{1'b0, 2'b10, 32'h100,  32'h0,        32'hAB22BEEF, "rd after half lo"};
    vecs[6]  = '{1'b1, 2'b01, 32'h103,  32'h55660000, 32'h0,        "wr half 103"};
    vecs[7]  = '{1'b0, 2'b00, 32'h102,  32'h0,        32'h5566BEEF, "rd byte-size full word"};
    vecs[8]  = '{1'b1, 2'b10, 32'h4000, 32'hCAFEF00D, 32'h0,        "wr alias 4000"};
    vecs[9]  = '{1'b0, 2'b10, 32'h0,    32'h0,        32'hCAFEF00D, "rd alias 0"};
    vecs[10] = '{1'b1, 2'b11, 32'h10,   32'h01020304, 32'h0,        "wr size3 10"};
    vecs[11] = '{1'b0, 2'b10, 32'h10,   32'h0,        32'h01020304, "rd size3 10"};
    vecs[12] = '{1'b1, 2'b00, 32'h11,   32'h0000EE00, 32'h0,        "wr byte 11"};
    vecs[13] = '{1'b0, 2'b10, 32'h10,   32'h0,        32'h0102EE04, "rd after byte 11"};

    sel = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset data_ok L3", 32'(dok0), 32'd0);
    check("reset rdata L3", rdata0, 32'd0);
    check("reset data_ok L1", 32'(dok1), 32'd0);
    check("reset rdata L1", rdata1, 32'd0);

    foreach (vecs[i]) begin
      txn(1'b0, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);
    end

    // req held high across three reads
    @(posedge clk); #1;
    sel = 1'b0; req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h100;
    nd = 0;
    overlap = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (aok0 && dok0) overlap++;
      if (dok0) begin
        nd++;
        check("b2b rdata", rdata0, 32'h5566BEEF);
      end
      if (aok0) begin
        acc_cyc.push_back(c);
        if (acc_cyc.size() == 3) begin
          @(posedge clk); #1 req = 1'b0;
        end
      end
    end
    check("b2b accepts", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() >= 3) begin
      check("b2b spacing 1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      check("b2b spacing 2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    end
    check("b2b data_ok count", 32'(nd), 32'd3);
    check("b2b overlap", 32'(overlap), 32'd0);
    last_rd[0] = 32'h5566BEEF;

    // reset in the second WAIT cycle of a write
    txn(1'b0, 1'b1, 2'b10, 32'h200, 32'h12345678, 32'h0, "wr pre 200");
    @(posedge clk); #1;
    sel = 1'b0; req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h200; wdata = 32'hDEADBEEF;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = aok0;
    end
    check("abort accept", 32'(acc), 32'd1);
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dok0) nd++;
    end
    check("abort no data_ok", 32'(nd), 32'd0);
    check("abort rdata reset", rdata0, 32'd0);
    last_rd[0] = '0;

    // req high through a reset pulse: accept in the first cycle after rst falls
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h200;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("accept after reset", 32'(aok0), 32'd1);
    @(posedge clk); #1 req = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = dok0;
    end
    check("abort read data_ok", 32'(acc), 32'd1);
    check("abort read prior value", rdata0, 32'h12345678);
    last_rd[0] = 32'h12345678;

    // LATENCY = 1 instance
    txn(1'b1, 1'b1, 2'b10, 32'h8, 32'hA5A5A5A5, 32'h0,        "L1 wr word 8");
    txn(1'b1, 1'b0, 2'b10, 32'h8, 32'h0,        32'hA5A5A5A5, "L1 rd word 8");
    txn(1'b1, 1'b1, 2'b01, 32'hA, 32'h77770000, 32'h0,        "L1 wr half A");
    txn(1'b1, 1'b0, 2'b10, 32'h8, 32'h0,        32'h7777A5A5, "L1 rd after half");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
